// File: rtl/sys_bus_pkg.sv
// Shared system-bus definitions: default widths and bridge FSM states.
// Imported by every bus bridge in the interconnect.
package sys_bus_pkg;

  localparam int SYS_AW = 32;
  localparam int SYS_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/sys_bus_cdc.sv
// Per-slave bus bridge: registers a one-cycle strobe, replays it downstream,
// returns the slave response, isolates on PLL unlock, bounds hung slaves.
module sys_bus_cdc
  import sys_bus_pkg::*;
#(
  parameter int AW      = SYS_AW,
  parameter int DW      = SYS_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_locked_i,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  input  logic          m_wen,
  input  logic          m_ren,
  output logic [DW-1:0] m_rdata,
  output logic          m_err,
  output logic          m_ack,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_wen,
  output logic          s_ren,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_err,
  input  logic          s_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic          accept;

  logic [AW-1:0] s_addr_d;
  logic [DW-1:0] s_wdata_d, m_rdata_d;
  logic          s_wen_d, s_ren_d;
  logic          m_ack_d, m_err_d;

  assign accept = m_wen | m_ren;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
    end
  end

  // s_ack wins over both abort and timeout in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = pll_locked_i ? REQ : RESP;
      end
      REQ: begin
        if (s_ack || !pll_locked_i)
          state_d = RESP;
        else
          state_d = WAIT;
      end
      WAIT: begin
        if (s_ack || !pll_locked_i)
          state_d = RESP;
        else if (cnt_q == CNT_MAX)
          state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    s_addr_d  = s_addr;
    s_wdata_d = s_wdata;
    s_wen_d   = 1'b0;
    s_ren_d   = 1'b0;
    m_ack_d   = 1'b0;
    m_rdata_d = m_rdata;
    m_err_d   = m_err;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d = m_wen;
          if (pll_locked_i) begin
            s_addr_d  = m_addr;
            s_wdata_d = m_wdata;
            s_wen_d   = m_wen;
            s_ren_d   = ~m_wen;
          end else begin
            m_ack_d   = 1'b1;
            m_err_d   = 1'b1;
            m_rdata_d = '0;
          end
        end
      end
      REQ, WAIT: begin
        cnt_d = (state_q == REQ) ? '0 : cnt_q + CW'(1);
        if (state_d == RESP) begin
          m_ack_d = 1'b1;
          if (s_ack) begin
            m_err_d   = s_err;
            m_rdata_d = wr_q ? '0 : s_rdata;
          end else begin
            m_err_d   = 1'b1;
            m_rdata_d = '0;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_addr  <= '0;
      s_wdata <= '0;
      s_wen   <= 1'b0;
      s_ren   <= 1'b0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
    end else begin
      s_addr  <= s_addr_d;
      s_wdata <= s_wdata_d;
      s_wen   <= s_wen_d;
      s_ren   <= s_ren_d;
      m_ack   <= m_ack_d;
      m_err   <= m_err_d;
      m_rdata <= m_rdata_d;
    end
  end

endmodule

// File: tb/tb_sys_bus_cdc.sv
// Bench for sys_bus_cdc: vector table, randomized transactions against a
// transaction-level model, and hand-written reset sequences.
module tb_sys_bus_cdc;

  localparam int TMO = 8;
  localparam int WIN = 14;
  localparam int NONE = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_locked_i;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_wen, m_ren, m_err, m_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_wen, s_ren, s_err, s_ack;

  int total = 0;
  int bad = 0;

  sys_bus_cdc #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pll_locked_i(pll_locked_i),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_ren(m_ren),
    .m_rdata(m_rdata), .m_err(m_err), .m_ack(m_ack),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen), .s_ren(s_ren),
    .s_rdata(s_rdata), .s_err(s_err), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        wr, rd, pll;
    int          d, p, xc;
    logic        serr;
    logic [31:0] srd, addr, wd;
    int          cyc;
    logic        err;
    logic [31:0] rdv;
    logic        ewen, eren;
  } vec_t;

  vec_t vq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Response time is one cycle after the earliest of: slave ack,
  // PLL drop, or the last wait cycle; ack wins a tie.
  function automatic void model(input logic wr, input logic pll0,
      input int d, input int p, input logic serr, input logic [31:0] srd,
      output int cyc, output logic err, output logic [31:0] rdv,
      output logic ewen, output logic eren);
    int a, e;
    ewen = 1'b0;
    eren = 1'b0;
    if (!pll0) begin
      cyc = 1; err = 1'b1; rdv = '0;
      return;
    end
    ewen = wr;
    eren = !wr;
    a = 1 + d;
    e = TMO + 1;
    if (p < e) e = p;
    if (a <= e) begin
      cyc = a + 1; err = serr; rdv = wr ? 32'h0 : srd;
    end else begin
      cyc = e + 1; err = 1'b1; rdv = '0;
    end
  endfunction

  task automatic run(input vec_t v);
    int nw, nr, na, scyc, acyc;
    logic [31:0] sa, sw, ard;
    logic aerr;
    nw = 0; nr = 0; na = 0; scyc = -1; acyc = -1;
    sa = '0; sw = '0; ard = '0; aerr = 1'b0;
    pll_locked_i = v.pll;
    m_wen = v.wr; m_ren = v.rd;
    m_addr = v.addr; m_wdata = v.wd;
    s_ack = 1'b0;
    for (int c = 1; c <= WIN; c++) begin
      step();
      if (s_wen) begin nw++; scyc = c; sa = s_addr; sw = s_wdata; end
      if (s_ren) begin nr++; scyc = c; sa = s_addr; sw = s_wdata; end
      if (m_ack) begin na++; acyc = c; ard = m_rdata; aerr = m_err; end
      m_wen = (c == v.xc);
      m_ren = (c == v.xc);
      m_addr = $urandom;
      m_wdata = $urandom;
      if (c >= v.p) pll_locked_i = 1'b0;
      s_ack = (c == 1 + v.d);
      s_err = s_ack ? v.serr : 1'($urandom);
      s_rdata = s_ack ? v.srd : $urandom;
    end
    pll_locked_i = 1'b1;
    s_ack = 1'b0; m_wen = 1'b0; m_ren = 1'b0;
    chk({v.nm, " wen_cnt"}, nw, {31'b0, v.ewen});
    chk({v.nm, " ren_cnt"}, nr, {31'b0, v.eren});
    chk({v.nm, " ack_cnt"}, na, 1);
    chk({v.nm, " ack_cyc"}, acyc, v.cyc);
    chk({v.nm, " m_err"}, {31'b0, aerr}, {31'b0, v.err});
    chk({v.nm, " m_rdata"}, ard, v.rdv);
    if (v.ewen || v.eren) begin
      chk({v.nm, " strobe_cyc"}, scyc, 1);
      chk({v.nm, " s_addr"}, sa, v.addr);
      chk({v.nm, " s_wdata"}, sw, v.wd);
    end
  endtask

  task automatic add(input string nm, input logic wr, input logic rd,
      input logic pll, input int d, input int p, input int xc,
      input logic serr, input logic [31:0] srd, input logic [31:0] addr,
      input logic [31:0] wd, input int cyc, input logic err,
      input logic [31:0] rdv, input logic ewen, input logic eren);
    vec_t v;
    v.nm = nm; v.wr = wr; v.rd = rd; v.pll = pll;
    v.d = d; v.p = p; v.xc = xc; v.serr = serr; v.srd = srd;
    v.addr = addr; v.wd = wd; v.cyc = cyc; v.err = err;
    v.rdv = rdv; v.ewen = ewen; v.eren = eren;
    vq.push_back(v);
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, " m_ack"}, {31'b0, m_ack}, 0);
    chk({nm, " m_err"}, {31'b0, m_err}, 0);
    chk({nm, " m_rdata"}, m_rdata, 0);
    chk({nm, " s_wen"}, {31'b0, s_wen}, 0);
    chk({nm, " s_ren"}, {31'b0, s_ren}, 0);
    chk({nm, " s_addr"}, s_addr, 0);
    chk({nm, " s_wdata"}, s_wdata, 0);
  endtask

  initial begin
    vec_t v;
    int na;
    rst = 1'b1; pll_locked_i = 1'b1;
    m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_ren = 1'b0;
    s_rdata = '0; s_err = 1'b0; s_ack = 1'b0;
    repeat (3) step();
    chk_idle_zero("reset");
    rst = 1'b0;
    step();

    add("wr_fast", 1, 0, 1, 0, NONE, -1, 0, 32'h0, 32'h10, 32'hDEADBEEF, 2, 0, 0, 1, 0);
    add("rd_d3", 0, 1, 1, 3, NONE, -1, 0, 32'h12345678, 32'h44, 32'h0, 5, 0, 32'h12345678, 0, 1);
    add("rd_hang", 0, 1, 1, NONE, NONE, -1, 0, 32'h0, 32'h48, 32'h0, 10, 1, 0, 0, 1);
    add("wr_nopll", 1, 0, 0, 0, NONE, -1, 0, 32'hFFFF, 32'h50, 32'h1, 1, 1, 0, 0, 0);
    add("wr_relock", 1, 0, 1, 0, NONE, -1, 0, 32'h0, 32'h20, 32'h11, 2, 0, 0, 1, 0);
    add("rd_2nd_wait", 0, 1, 1, 5, NONE, 3, 0, 32'hCAFE0001, 32'h60, 32'h0, 7, 0, 32'hCAFE0001, 0, 1);
    add("dual", 1, 1, 1, 1, NONE, -1, 0, 32'hAAAAAAAA, 32'h64, 32'h5A5A, 3, 0, 0, 1, 0);
    add("rd_serr", 0, 1, 1, 0, NONE, -1, 1, 32'h55, 32'h68, 32'h0, 2, 1, 32'h55, 0, 1);
    add("rd_last_wait", 0, 1, 1, 8, NONE, -1, 0, 32'h0BADF00D, 32'h6C, 32'h0, 10, 0, 32'h0BADF00D, 0, 1);
    add("rd_late", 0, 1, 1, 9, NONE, -1, 0, 32'h1, 32'h70, 32'h0, 10, 1, 0, 0, 1);
    add("rd_abort", 0, 1, 1, 6, 3, -1, 0, 32'h2, 32'h74, 32'h0, 4, 1, 0, 0, 1);
    add("rd_ack_vs_drop", 0, 1, 1, 3, 4, -1, 0, 32'h777, 32'h78, 32'h0, 5, 0, 32'h777, 0, 1);
    add("wr_drop_req", 1, 0, 1, 2, 1, -1, 0, 32'h3, 32'h7C, 32'h9, 2, 1, 0, 1, 0);
    add("rd_2nd_resp", 0, 1, 1, 0, NONE, 2, 0, 32'h99, 32'h80, 32'h0, 2, 0, 32'h99, 0, 1);
    add("wr_serr", 1, 0, 1, 0, NONE, -1, 1, 32'hABCD, 32'h84, 32'h7, 2, 1, 0, 1, 0);
    foreach (vq[i]) run(vq[i]);

    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(1, 3);
      v.nm = $sformatf("rnd%0d", i);
      v.wr = k[0];
      v.rd = k[1];
      v.pll = ($urandom_range(0, 7) != 0);
      v.d = $urandom_range(0, 11);
      v.p = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : NONE;
      v.xc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : -1;
      v.serr = 1'($urandom);
      v.srd = $urandom;
      v.addr = $urandom;
      v.wd = $urandom;
      model(v.wr, v.pll, v.d, v.p, v.serr, v.srd, v.cyc, v.err, v.rdv, v.ewen, v.eren);
      if (v.xc >= v.cyc) v.xc = -1;
      run(v);
    end

    // reset while the slave is stalling
    m_ren = 1'b1; m_addr = 32'h90;
    step();
    m_ren = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk_idle_zero("rst_wait");
    rst = 1'b0;
    na = 0;
    for (int c = 0; c < WIN; c++) begin
      step();
      if (m_ack || s_ren || s_wen) na++;
    end
    chk("rst_wait quiet", na, 0);

    v.nm = "rd_after_rst"; v.wr = 0; v.rd = 1; v.pll = 1; v.d = 2;
    v.p = NONE; v.xc = -1; v.serr = 0; v.srd = 32'h600DCAFE;
    v.addr = 32'h94; v.wd = 32'h0; v.cyc = 4; v.err = 0;
    v.rdv = 32'h600DCAFE; v.ewen = 0; v.eren = 1;
    run(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
